// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared idle-level helper and repeat-FSM encoding for btn_debounce_multi
package btn_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_DLY  = 2'd1,
      R_PER  = 2'd2
   } rpt_state_t;

   // Idle pin level equals ACTIVE_LOW: an active-low button idles high.
   function automatic logic idle_lvl(input int active_low);
      return (active_low != 0);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: 2-FF sync, stability counter, press/release strobes
// Optional auto-repeat FSM when BTN_REPEAT_EN is defined.
module debounce_ch
   import btn_pkg::*;
#(
   parameter int DEB_CYC    = 800000,
   parameter int CNT_W      = 20,
   parameter int ACTIVE_LOW = 1,
   parameter int RPT_DLY    = 25000000,
   parameter int RPT_PER    = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_pressed,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam logic IDLE = idle_lvl(ACTIVE_LOW);

   if ((DEB_CYC < 1) || (RPT_DLY < 1) || (RPT_PER < 1) ||
       ((64'd1 << CNT_W) <= 64'(DEB_CYC))) begin : g_bad_cfg
      $error("debounce_ch: invalid parameter set");
   end

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_pressed;
   logic             r_press;
   logic             r_release;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;

   assign w_accept = (r_cnt == CNT_W'(DEB_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= IDLE;
         r_sync2   <= IDLE;
         r_stable  <= IDLE;
         r_pressed <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            // Strobes are registered alongside the level so all three change together.
            r_cnt     <= '0;
            r_stable  <= r_sync2;
            r_pressed <= r_sync2 ^ IDLE;
            r_press   <= r_sync2 ^ IDLE;
            r_release <= ~(r_sync2 ^ IDLE);
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level   = r_stable;
   assign o_pressed = r_pressed;
   assign o_press   = r_press;
   assign o_release = r_release;

`ifdef BTN_REPEAT_EN
   localparam int CNT_R = $clog2(max_int(RPT_DLY, RPT_PER) + 1);

   rpt_state_t       r_rstate;
   rpt_state_t       w_rstate_nxt;
   logic [CNT_R-1:0] r_rcnt;
   logic [CNT_R-1:0] w_rcnt_nxt;
   logic             w_repeat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstate <= R_IDLE;
         r_rcnt   <= '0;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_rcnt   <= w_rcnt_nxt;
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rcnt_nxt   = r_rcnt;
      w_repeat     = 1'b0;
      if (r_release) begin
         w_rstate_nxt = R_IDLE;
         w_rcnt_nxt   = '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (r_press) begin
                  w_rstate_nxt = R_DLY;
                  w_rcnt_nxt   = '0;
               end
            end
            R_DLY: begin
               if (r_rcnt == CNT_R'(RPT_DLY - 1)) begin
                  w_repeat     = 1'b1;
                  w_rstate_nxt = R_PER;
                  w_rcnt_nxt   = '0;
               end else begin
                  w_rcnt_nxt = r_rcnt + 1'b1;
               end
            end
            R_PER: begin
               if (r_rcnt == CNT_R'(RPT_PER - 1)) begin
                  w_repeat   = 1'b1;
                  w_rcnt_nxt = '0;
               end else begin
                  w_rcnt_nxt = r_rcnt + 1'b1;
               end
            end
            default: begin
               w_rstate_nxt = R_IDLE;
               w_rcnt_nxt   = '0;
            end
         endcase
      end
   end

   assign o_repeat = w_repeat;
`else
   assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel button conditioner top; auto-repeat under BTN_REPEAT_EN
module btn_debounce_multi #(
   parameter int N_CH       = 4,
   parameter int DEB_CYC    = 800000,
   parameter int CNT_W      = 20,
   parameter int ACTIVE_LOW = 1,
   parameter int RPT_DLY    = 25000000,
   parameter int RPT_PER    = 5000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_pressed,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] repeat_pulse
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .DEB_CYC    (DEB_CYC),
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW),
         .RPT_DLY    (RPT_DLY),
         .RPT_PER    (RPT_PER)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_btn     (btn_in[g]),
         .o_level   (btn_level[g]),
         .o_pressed (btn_pressed[g]),
         .o_press   (press_pulse[g]),
         .o_release (release_pulse[g]),
         .o_repeat  (repeat_pulse[g])
      );
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - self-checking bench for btn_debounce_multi (BTN_REPEAT_EN optional)
module tb_btn_debounce_multi;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_in;
   logic [3:0] btn_level;
   logic [3:0] btn_pressed;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] repeat_pulse;

   int total;
   int bad;

`ifdef BTN_REPEAT_EN
   localparam logic [3:0] RPT_MASK = 4'hF;
`else
   localparam logic [3:0] RPT_MASK = 4'h0;
`endif

   btn_debounce_multi #(
      .N_CH       (4),
      .DEB_CYC    (8),
      .CNT_W      (4),
      .ACTIVE_LOW (1),
      .RPT_DLY    (20),
      .RPT_PER    (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .btn_pressed   (btn_pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] in;
      int         cyc;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] pp;
      logic [3:0] rp;
      logic [3:0] rpt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] in, input int cyc, input logic [3:0] lvl,
                               input logic [3:0] prs, input logic [3:0] pp,
                               input logic [3:0] rp, input logic [3:0] rpt);
      vec_t v;
      v.in  = in;
      v.cyc = cyc;
      v.lvl = lvl;
      v.prs = prs;
      v.pp  = pp;
      v.rp  = rp;
      v.rpt = rpt & RPT_MASK;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, ".level"},   btn_level,     4'hF);
      chk({nm, ".pressed"}, btn_pressed,   4'h0);
      chk({nm, ".press"},   press_pulse,   4'h0);
      chk({nm, ".release"}, release_pulse, 4'h0);
      chk({nm, ".repeat"},  repeat_pulse,  4'h0);
   endtask

   int n_press;

   task automatic step_cnt();
      step();
      n_press += int'(press_pulse[1]);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      btn_in = 4'hF;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;

      // ch0: press, repeat train, release (release_pulse lands on the +50 repeat slot)
      vecs.push_back(mk(4'hE,  9, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE, 18, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  4, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1));
      vecs.push_back(mk(4'hE,  5, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hE,  1, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1));
      vecs.push_back(mk(4'hE,  6, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1));
      vecs.push_back(mk(4'hE,  2, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hF,  4, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1));
      vecs.push_back(mk(4'hF,  5, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0));
      vecs.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hF, 20, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      // ch2+ch3 together, ch2 released 30 cycles after the fall, then ch3
      vecs.push_back(mk(4'h3, 10, 4'h3, 4'hC, 4'hC, 4'h0, 4'h0));
      vecs.push_back(mk(4'h3,  1, 4'h3, 4'hC, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'h3, 19, 4'h3, 4'hC, 4'h0, 4'h0, 4'hC));
      vecs.push_back(mk(4'h7, 10, 4'h7, 4'h8, 4'h0, 4'h4, 4'h0));
      vecs.push_back(mk(4'h7,  1, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(4'hF, 10, 4'hF, 4'h0, 4'h0, 4'h8, 4'h0));
      vecs.push_back(mk(4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));

      repeat (3) step();
      chk_idle("in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         chk_idle($sformatf("post_reset[%0d]", i));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         btn_in = vecs[i].in;
         repeat (vecs[i].cyc) step();
         chk($sformatf("vec%0d.level", i),   btn_level,     vecs[i].lvl);
         chk($sformatf("vec%0d.pressed", i), btn_pressed,   vecs[i].prs);
         chk($sformatf("vec%0d.press", i),   press_pulse,   vecs[i].pp);
         chk($sformatf("vec%0d.release", i), release_pulse, vecs[i].rp);
         chk($sformatf("vec%0d.repeat", i),  repeat_pulse,  vecs[i].rpt);
      end

      // ch1 bounce: only the final steady fall may be accepted
      n_press = 0;
      btn_in = 4'hD; repeat (5) step_cnt();
      btn_in = 4'hF; repeat (2) step_cnt();
      btn_in = 4'hD; repeat (5) step_cnt();
      btn_in = 4'hF; repeat (2) step_cnt();
      btn_in = 4'hD;
      for (int i = 1; i <= 9; i++) begin
         step_cnt();
         chk($sformatf("bounce_early[%0d]", i), press_pulse, 4'h0);
      end
      step_cnt();
      chk("bounce_press", press_pulse, 4'h2);
      chk("bounce_level", btn_level, 4'hD);
      repeat (20) step_cnt();
      chk("bounce_count", 4'(n_press), 4'h1);
      btn_in = 4'hF;
      repeat (12) step();
      chk("bounce_released", btn_level, 4'hF);

      // reset asserted mid-window with ch0 held, released with ch0 still held
      btn_in = 4'hE;
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.level",   btn_level,   4'hF);
      chk("midrst.pressed", btn_pressed, 4'h0);
      chk("midrst.press",   press_pulse, 4'h0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk($sformatf("midrst_wait[%0d].press", i), press_pulse, 4'h0);
         chk($sformatf("midrst_wait[%0d].level", i), btn_level, 4'hF);
      end
      step();
      chk("midrst_after.press",   press_pulse, 4'h1);
      chk("midrst_after.level",   btn_level,   4'hE);
      chk("midrst_after.pressed", btn_pressed, 4'h1);
      step();
      chk("midrst_after2.press", press_pulse, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
